// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte-stream
// requesters. Round-robin grant, holds tx_start until tx_clear, and a
// watchdog flags a transmitter that never completes.
// Optional build macro: UART_ARB_PRIO_EN (requester 0 gets absolute priority;
// the others round-robin among themselves).
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int GID_W          = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_clear,
    input  logic                 tx_busy,
    input  logic                 err_clr,
    output logic [GID_W-1:0]     grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]       state_q,       state_d;
    logic [7:0]       tx_data_q,     tx_data_d;
    logic             tx_start_q,    tx_start_d;
    logic [GID_W-1:0] grant_id_q,    grant_id_d;
    logic [GID_W-1:0] last_grant_q,  last_grant_d;
    logic [31:0]      cnt_q,         cnt_d;
    logic             timeout_err_q, timeout_err_d;

    logic win_found;
    int   win_idx;
    logic eligible;
    logic accept;
    logic timeout_hit;

    // Pick the first valid requester after last_grant, wrapping around.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = 0;
        idx       = 0;
`ifdef UART_ARB_PRIO_EN
        if (req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = 0;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
`ifdef UART_ARB_PRIO_EN
            if (idx != 0 && req_valid[idx] && !win_found) begin
`else
            if (req_valid[idx] && !win_found) begin
`endif
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Grant is offered only while idle and the transmitter is quiet.
    always_comb begin
        eligible  = (state_q == IDLE) && !tx_busy && !tx_clear;
        req_ready = '0;
        if (eligible && win_found)
            req_ready[win_idx] = 1'b1;
        accept      = |(req_valid & req_ready);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == WAIT) && !tx_clear &&
                      (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    end

    // Next-state: IDLE accepts a byte, WAIT holds tx_start until clear or timeout.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = tx_start_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        timeout_err_d = err_clr ? 1'b0 : timeout_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_data_d  = req_data[win_idx*8 +: 8];
                    tx_start_d = 1'b1;
                    grant_id_d = GID_W'(win_idx);
`ifdef UART_ARB_PRIO_EN
                    // Requester 0 sits outside the rotation.
                    if (win_idx != 0)
                        last_grant_d = GID_W'(win_idx);
`else
                    last_grant_d = GID_W'(win_idx);
`endif
                    cnt_d      = '0;
                    state_d    = WAIT;
                end
            end
            default: begin
                cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                if (tx_clear) begin
                    tx_start_d = 1'b0;
                    state_d    = IDLE;
                end else if (timeout_hit) begin
                    // Byte is dropped; set beats a coincident err_clr.
                    tx_start_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            grant_id_q    <= '0;
            last_grant_q  <= GID_W'(NUM_REQ - 1);
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_id_q;
    assign busy        = (state_q == WAIT);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT, a
// transaction-level round-robin model predicts the grant sequence, and a
// monitor pops predictions on each tx_start rise.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 1000;
    localparam int GW = 2;
    localparam int AUTO = 0, NEVER = 1, EXACT = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_clear = 1'b0;
    logic           tb_busy = 1'b0;
    logic           force_busy = 1'b0;
    logic           tx_busy;
    logic           err_clr = 1'b0;
    logic [GW-1:0]  grant_id;
    logic           busy;
    logic           timeout_err;

    assign tx_busy = tb_busy | force_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .GID_W(GW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
        .tx_clear(tx_clear), .tx_busy(tx_busy), .err_clr(err_clr),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int mode = AUTO;

    typedef struct {int id; logic [7:0] d;} exp_t;
    exp_t       expq[$];
    logic [7:0] pend[N][$];
    int         mlast = N - 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit pend_empty();
        for (int i = 0; i < N; i++) if (pend[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Round-robin over the requesters that still hold bytes.
    task automatic predict();
        logic [7:0] mq[N][$];
        int pick;
        bit any;
        exp_t e;
        for (int i = 0; i < N; i++) mq[i] = pend[i];
        while (1) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) if (mq[i].size() > 0) any = 1'b1;
            if (!any) break;
            pick = -1;
`ifdef UART_ARB_PRIO_EN
            if (mq[0].size() > 0) pick = 0;
`endif
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (mlast + k) % N;
`ifdef UART_ARB_PRIO_EN
                if (i == 0) continue;
`endif
                if (pick < 0 && mq[i].size() > 0) pick = i;
            end
            e.id = pick;
            e.d  = mq[pick].pop_front();
            expq.push_back(e);
`ifdef UART_ARB_PRIO_EN
            if (pick != 0) mlast = pick;
`else
            mlast = pick;
`endif
        end
    endtask

    // Requesters: hold valid/data until accepted, then advance their queue.
    initial forever begin
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
            req_valid[i]       = (pend[i].size() > 0);
            req_data[8*i +: 8] = (pend[i].size() > 0) ? pend[i][0] : 8'h00;
        end
    end

    // Transmitter model.
    initial forever begin
        int d;
        @(posedge clk);
        #1;
        if (tx_start) begin
            tb_busy = 1'b1;
            if (mode == AUTO) begin
                d = $urandom_range(1, 25);
                repeat (d) @(posedge clk);
                #1 tx_clear = 1'b1;
                @(posedge clk);
                #1 tx_clear = 1'b0;
            end else if (mode == EXACT) begin
                repeat (TO - 1) @(posedge clk);
                #1 tx_clear = 1'b1;
                @(posedge clk);
                #1 tx_clear = 1'b0;
            end else begin
                while (tx_start) begin
                    @(posedge clk);
                    #1;
                end
            end
            tb_busy = 1'b0;
        end
    end

    // Monitor: pops a prediction on every tx_start rise.
    logic       prev_start = 1'b0;
    logic [7:0] cur_d = 8'h00;
    initial forever begin
        logic [N-1:0] ro;
        exp_t e;
        @(negedge clk);
        if (rst) prev_start = 1'b0;
        else begin
            ro = req_ready & (req_ready - 1'b1);
            chk("ready_onehot", ro, 0);
            if (busy) chk("ready_in_wait", req_ready, 0);
            if (tx_start && !prev_start) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got id %0d data 0x%0h expected none", grant_id, tx_data);
                end else begin
                    e = expq.pop_front();
                    chk("grant_id", grant_id, e.id);
                    chk("tx_data", tx_data, e.d);
                    chk("busy_on_start", busy, 1);
                    cur_d = e.d;
                end
            end else if (tx_start) chk("tx_data_stable", tx_data, cur_d);
            prev_start = tx_start;
        end
    end

    task automatic wait_done(input string nm, input int budget);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (pend_empty() && expq.size() == 0 && !busy && !tx_start && !tx_clear) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_done"}, ok, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_sig(input string nm, input bit lvl, input int budget);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (tx_start == lvl) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1);
    endtask

    initial begin
        int t0;
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ready", req_ready, 0);

        // All four requesters, plus a second byte on requester 0.
        for (int i = 0; i < N; i++) pend[i].push_back(8'(8'hA0 + i));
        pend[0].push_back(8'hA4);
        predict();
        wait_done("rr_all", 400);

        // Single requester 2.
        pend[2].push_back(8'h5C);
        predict();
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready[2]) begin ok = 1'b1; break; end
        end
        chk("rdy2_seen", ok, 1);
        @(negedge clk);
        chk("r2_tx_start", tx_start, 1);
        chk("r2_tx_data", tx_data, 8'h5C);
        chk("r2_grant_id", grant_id, 2);
        chk("r2_busy", busy, 1);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (tx_clear) begin ok = 1'b1; break; end
        end
        chk("r2_clear_seen", ok, 1);
        @(negedge clk);
        chk("r2_start_dropped", tx_start, 0);
        wait_done("single", 50);

        // Randomized bursts.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                int n;
                n = $urandom_range(0, 3);
                repeat (n) pend[i].push_back(8'($urandom));
            end
            predict();
            wait_done("rand", 1000);
        end

        // Watchdog timeout.
        mode = NEVER;
        pend[1].push_back(8'h3C);
        predict();
        wait_sig("to_rise", 1'b1, 20);
        t0 = cyc;
        wait_sig("to_fall", 1'b0, 1100);
        chk("to_length", cyc - t0, TO);
        chk("to_err_set", timeout_err, 1);
        chk("to_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", timeout_err, 1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("to_err_cleared", timeout_err, 0);
        wait_done("timeout", 50);

        // tx_clear on the last WAIT cycle beats the watchdog.
        mode = EXACT;
        pend[2].push_back(8'h77);
        predict();
        wait_done("coincident", 1300);
        chk("coinc_no_err", timeout_err, 0);

        // tx_busy held in IDLE blocks grants.
        mode = AUTO;
        force_busy = 1'b1;
        pend[0].push_back(8'h11);
        predict();
        repeat (10) begin
            @(negedge clk);
            chk("blk_ready", req_ready, 0);
            chk("blk_start", tx_start, 0);
        end
        @(posedge clk);
        #1 force_busy = 1'b0;
        @(negedge clk);
        chk("blk_release_ready", req_ready, 4'b0001);
        wait_done("busy_block", 60);

        // Reset in the middle of WAIT.
        mode = NEVER;
        pend[3].push_back(8'h99);
        predict();
        wait_sig("rstw_rise", 1'b1, 20);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstw_tx_start", tx_start, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_grant_id", grant_id, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        mlast = N - 1;
        mode = AUTO;
        for (int i = 0; i < N; i++) pend[i].push_back(8'(8'hB0 + i));
        predict();
        wait_done("post_reset", 400);

        chk("sb_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_chk++;
        n_fail++;
        $display("FAIL global_timeout: simulation still running at cycle %0d, required completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end
endmodule
